// File: rtl/fp2_result_writeback_pkg.sv
// Shared types and helpers for the F(p^2) result writeback stage.
// Holds the FSM encoding and destination address width helper.
`ifndef FP2_RESULT_WRITEBACK_PKG_SV
`define FP2_RESULT_WRITEBACK_PKG_SV
`define CLOG2(x) ($clog2(x))
`endif

package fp2_result_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } wb_state_e;

    // Destination write address is {slot, digit}
    function automatic int wr_addr_w(
        input int slots_log,
        input int digits_log
    );
        return slots_log + digits_log;
    endfunction

endpackage

// File: rtl/delay.sv
// Fixed-latency pipeline register.
// Used to align the read address/valid with memory read data.
module delay
    import fp2_result_writeback_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DELAY];
    logic [WIDTH-1:0] pipe_d [DELAY];

    // Shift the pipe by one stage
    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe registers, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/fp2_result_writeback.sv
// Copies c0 (and c1) result digits into a destination memory slot.
// Also reports whether every copied digit was zero.
module fp2_result_writeback
    import fp2_result_writeback_pkg::*;
#(
    parameter int RADIX      = 32,
    parameter int DIGITS     = 14,
    parameter int DIGITS_LOG = `CLOG2(DIGITS),
    parameter int SLOTS      = 16,
    parameter int SLOTS_LOG  = `CLOG2(SLOTS),
    localparam int WR_ADDR_W = wr_addr_w(SLOTS_LOG, DIGITS_LOG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  extension_field_op,
    input  logic [SLOTS_LOG-1:0]  dst_slot,
    output logic                  mem_c_0_rd_en,
    output logic [DIGITS_LOG-1:0] mem_c_0_rd_addr,
    input  logic [RADIX-1:0]      mem_c_0_dout,
    output logic                  mem_c_1_rd_en,
    output logic [DIGITS_LOG-1:0] mem_c_1_rd_addr,
    input  logic [RADIX-1:0]      mem_c_1_dout,
    output logic                  dst_0_wr_en,
    output logic [WR_ADDR_W-1:0]  dst_0_wr_addr,
    output logic [RADIX-1:0]      dst_0_din,
    output logic                  dst_1_wr_en,
    output logic [WR_ADDR_W-1:0]  dst_1_wr_addr,
    output logic [RADIX-1:0]      dst_1_din,
    output logic                  busy,
    output logic                  done,
    output logic                  is_zero
);

    localparam logic [DIGITS_LOG-1:0] LAST = DIGITS_LOG'(DIGITS - 1);

    wb_state_e             state_q, state_d;
    logic [DIGITS_LOG-1:0] cnt_q, cnt_d;
    logic [SLOTS_LOG-1:0]  slot_q, slot_d;
    logic                  ext_q, ext_d;
    logic                  acc_q, acc_d;
    logic                  iz_q, iz_d;

    logic                  rd_valid;
    logic [DIGITS_LOG:0]   dly_in;
    logic [DIGITS_LOG:0]   dly_out;
    logic                  wr_valid;
    logic [DIGITS_LOG-1:0] wr_digit;

    assign rd_valid = (state_q == ST_READ);
    assign dly_in   = {rd_valid, cnt_q};
    assign wr_valid = dly_out[DIGITS_LOG];
    assign wr_digit = dly_out[DIGITS_LOG-1:0];

    delay #(
        .WIDTH (DIGITS_LOG + 1),
        .DELAY (1)
    ) u_addr_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (dly_in),
        .dout (dly_out)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            ext_q   <= 1'b0;
            acc_q   <= 1'b0;
            iz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            ext_q   <= ext_d;
            acc_q   <= acc_d;
            iz_q    <= iz_d;
        end
    end

    // Next state, digit counter and command latches
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        ext_d   = ext_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    slot_d  = dst_slot;
                    ext_d   = extension_field_op;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + DIGITS_LOG'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:  state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Zero accumulator; result captured as the last digit lands
    always_comb begin
        acc_d = acc_q;
        iz_d  = iz_q;
        if (state_q == ST_IDLE && start) begin
            acc_d = 1'b1;
            iz_d  = 1'b0;
        end else if (wr_valid) begin
            acc_d = acc_q
                  & (mem_c_0_dout == '0)
                  & (~ext_q | (mem_c_1_dout == '0));
        end
        if (state_q == ST_DRAIN) begin
            iz_d = acc_d;
        end
    end

    // Port outputs; inactive addresses and data drive zero
    always_comb begin
        busy            = (state_q == ST_READ)
                        | (state_q == ST_DRAIN);
        done            = (state_q == ST_FINISH);
        is_zero         = iz_q;
        mem_c_0_rd_en   = rd_valid;
        mem_c_0_rd_addr = rd_valid ? cnt_q : '0;
        mem_c_1_rd_en   = rd_valid & ext_q;
        mem_c_1_rd_addr = mem_c_1_rd_en ? cnt_q : '0;
        dst_0_wr_en     = wr_valid;
        dst_0_wr_addr   = '0;
        dst_0_din       = '0;
        dst_1_wr_en     = wr_valid & ext_q;
        dst_1_wr_addr   = '0;
        dst_1_din       = '0;
        if (dst_0_wr_en) begin
            dst_0_wr_addr = {slot_q, wr_digit};
            dst_0_din     = mem_c_0_dout;
        end
        if (dst_1_wr_en) begin
            dst_1_wr_addr = {slot_q, wr_digit};
            dst_1_din     = mem_c_1_dout;
        end
    end

endmodule
